// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller. Two WIDTH-bit operands are added LSB-first,
//   one bit per clock, by two chained 1-bit half-adder cells and a carry
//   register. A requester starts an add with a start/done handshake.
//
//   Ports
//     clk    in   1      single clock, rising edge
//     rst    in   1      asynchronous, active-high reset
//     start  in   1      request; only looked at while idle
//     op_a   in   WIDTH  operand A, captured on the accepting edge
//     op_b   in   WIDTH  operand B, captured on the accepting edge
//     busy   out  1      high while the serial add is running
//     done   out  1      one-cycle pulse; sum/cout are valid
//     sum    out  WIDTH  (op_a + op_b) mod 2^WIDTH
//     cout   out  1      carry out of the top bit
//
//   An add takes WIDTH cycles in RUN followed by one DONE cycle. A new start
//   can be taken on the edge after DONE, so one add completes every WIDTH+2
//   cycles. sum/cout are written only on the last RUN edge and then hold.

module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Plain 1-bit half adder: sum is the XOR, carry is the AND.
    assign s = a ^ b;
    assign c = a & b;

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shift_a;
    logic [WIDTH-1:0]   shift_b;
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
    logic               s1;
    logic               c1;
    logic               s2;
    logic               c2;
    logic               carry_next;
    logic [WIDTH-1:0]   acc_next;

    // The first cell adds the two operand bits, the second folds in the
    // carry from the previous bit. At most one of c1/c2 can be set, so an OR
    // is enough to form the outgoing carry.
    half_adder_cell ha1 (
        .a (shift_a[0]),
        .b (shift_b[0]),
        .s (s1),
        .c (c1)
    );

    half_adder_cell ha2 (
        .a (s1),
        .b (carry),
        .s (s2),
        .c (c2)
    );

    assign carry_next = c1 | c2;
    assign acc_next   = {s2, acc[WIDTH-1:1]};
    assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

    // busy and done are decoded straight from the state so they change
    // exactly on state transitions and clear immediately on reset.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register. Reset drops straight back to IDLE from anywhere,
    // which also aborts an add in progress without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start is only honoured in IDLE; while running or in
    // DONE it is ignored and nothing is remembered for later.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured on the accepting edge; each RUN edge
    // consumes one bit from each shifter and pushes one result bit into the
    // top of acc. The visible sum/cout are only loaded on the final bit so a
    // partially built result never appears on the outputs. The counter is
    // left alone on the final bit so it never needs to wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_a <= op_a;
                        shift_b <= op_b;
                        carry   <= 1'b0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    acc     <= acc_next;
                    carry   <= carry_next;
                    if (last_bit) begin
                        sum  <= acc_next;
                        cout <= carry_next;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
